// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and helpers for the router round-robin arbiter
package router_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    localparam int DEF_CLIENTS = 2;
    localparam int DEF_BURST   = 4;

    // Increment modulo n; n need not be a power of two.
    function automatic int unsigned next_idx(input int unsigned i, input int unsigned n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/router_rr_pick.sv
// rtl/router_rr_pick.sv - combinational rotate-priority encoder starting at ptr
module router_rr_pick
    import router_pkg::*;
#(
    parameter int CLIENTS = DEF_CLIENTS,
    parameter int IDW     = $clog2(CLIENTS)
) (
    input  logic [CLIENTS-1:0] req,
    input  logic [IDW-1:0]     ptr,
    input  logic               en,
    output logic [CLIENTS-1:0] pick,
    output logic [IDW-1:0]     pick_id,
    output logic               pick_valid
);

    int idx;

    always_comb begin
        pick       = '0;
        pick_id    = '0;
        pick_valid = 1'b0;
        idx        = 0;
        if (en) begin
            for (int k = 0; k < CLIENTS; k++) begin
                idx = int'(ptr) + k;
                if (idx >= CLIENTS) idx = idx - CLIENTS;
                if (!pick_valid && req[idx]) begin
                    pick[idx]  = 1'b1;
                    pick_id    = IDW'(idx);
                    pick_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/router_rr_arbiter.sv
// rtl/router_rr_arbiter.sv - round-robin arbiter with burst hold for the router input FIFOs
module router_rr_arbiter
    import router_pkg::*;
#(
    parameter int CLIENTS = DEF_CLIENTS,
    parameter int BURST   = DEF_BURST
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cycle,
    input  logic [CLIENTS-1:0]         req,
    output logic [CLIENTS-1:0]         gnt,
    output logic                       gnt_valid,
    output logic [$clog2(CLIENTS)-1:0] gnt_id
);

    localparam int IDW  = $clog2(CLIENTS);
    localparam int CNTW = $clog2(BURST + 1);

    arb_state_t      st, st_n;
    logic [IDW-1:0]  ptr, ptr_n, owner, owner_n, owner_inc, pick_inc, start;
    logic [CNTW-1:0] cnt, cnt_n;
    logic            hold_hit, hold_gnt, burst_done;

    logic [CLIENTS-1:0] pick;
    logic [IDW-1:0]     pick_id;
    logic               pick_valid;

    assign owner_inc  = IDW'(next_idx(int'(owner), CLIENTS));
    assign pick_inc   = IDW'(next_idx(int'(pick_id), CLIENTS));
    assign hold_hit   = (st == HOLD) && req[owner];
    assign hold_gnt   = !reset && cycle && hold_hit;
    assign burst_done = (int'(cnt) + 1 == BURST);

    // A drained owner releases in the same cycle: search resumes just after it.
    assign start = (st == HOLD) ? owner_inc : ptr;

    router_rr_pick #(
        .CLIENTS (CLIENTS),
        .IDW     (IDW)
    ) u_pick (
        .req        (req),
        .ptr        (start),
        .en         (!reset && cycle && !hold_hit),
        .pick       (pick),
        .pick_id    (pick_id),
        .pick_valid (pick_valid)
    );

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        if (hold_gnt) begin
            gnt[owner] = 1'b1;
            gnt_id     = owner;
        end else if (pick_valid) begin
            gnt    = pick;
            gnt_id = pick_id;
        end
    end

    assign gnt_valid = |gnt;

    always_comb begin
        st_n    = st;
        ptr_n   = ptr;
        owner_n = owner;
        cnt_n   = cnt;
        if (cycle) begin
            if (hold_hit) begin
                cnt_n = cnt + CNTW'(1);
                if (burst_done) begin
                    ptr_n = owner_inc;
                    st_n  = IDLE;
                end
            end else if (pick_valid) begin
                owner_n = pick_id;
                cnt_n   = CNTW'(1);
                if (BURST == 1) begin
                    ptr_n = pick_inc;
                    st_n  = IDLE;
                end else begin
                    st_n  = HOLD;
                end
            end else if (st == HOLD) begin
                ptr_n = owner_inc;
                st_n  = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st    <= IDLE;
            ptr   <= '0;
            owner <= '0;
            cnt   <= '0;
        end else begin
            st    <= st_n;
            ptr   <= ptr_n;
            owner <= owner_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_router_rr_arbiter.sv
// tb/tb_router_rr_arbiter.sv - self-checking bench for router_rr_arbiter in three configurations
module tb_router_rr_arbiter;

    typedef struct {
        bit         rst;
        bit         cyc;
        logic [2:0] req;
        int         w;
    } vec_t;

    typedef struct {
        int ptr;
        int owner;
        int used;
        bit holding;
    } model_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut 0: CLIENTS=3 BURST=4, dut 1: CLIENTS=3 BURST=1, dut 2: CLIENTS=2 BURST=4
    logic       rst_v [3];
    logic       cyc_v [3];
    logic [2:0] req_a [3];

    logic [2:0] gnt0, gnt1;
    logic [1:0] gnt2;
    logic       v0, v1, v2;
    logic [1:0] id0, id1;
    logic       id2;

    int n_checks = 0;
    int n_fail   = 0;
    int nn [3] = '{3, 3, 2};
    int bb [3] = '{4, 1, 4};
    model_t m [3];

    router_rr_arbiter #(.CLIENTS(3), .BURST(4)) u_c3b4 (
        .clk(clk), .reset(rst_v[0]), .cycle(cyc_v[0]), .req(req_a[0]),
        .gnt(gnt0), .gnt_valid(v0), .gnt_id(id0)
    );
    router_rr_arbiter #(.CLIENTS(3), .BURST(1)) u_c3b1 (
        .clk(clk), .reset(rst_v[1]), .cycle(cyc_v[1]), .req(req_a[1]),
        .gnt(gnt1), .gnt_valid(v1), .gnt_id(id1)
    );
    router_rr_arbiter #(.CLIENTS(2), .BURST(4)) u_c2b4 (
        .clk(clk), .reset(rst_v[2]), .cycle(cyc_v[2]), .req(req_a[2][1:0]),
        .gnt(gnt2), .gnt_valid(v2), .gnt_id(id2)
    );

    task automatic check(input int d, input string nm, input int w);
        logic [2:0] ag, eg;
        logic       av;
        logic [1:0] aid, eid;
        case (d)
            0:       begin ag = gnt0;          av = v0; aid = id0;          end
            1:       begin ag = gnt1;          av = v1; aid = id1;          end
            default: begin ag = {1'b0, gnt2};  av = v2; aid = {1'b0, id2};  end
        endcase
        eg  = (w < 0) ? 3'b000 : 3'(1 << w);
        eid = (w < 0) ? 2'd0 : 2'(w);
        n_checks++;
        if (ag !== eg) begin
            n_fail++;
            $display("FAIL %s dut%0d gnt got %b expected %b", nm, d, ag, eg);
        end
        n_checks++;
        if (av !== (w >= 0)) begin
            n_fail++;
            $display("FAIL %s dut%0d gnt_valid got %b expected %b", nm, d, av, (w >= 0));
        end
        n_checks++;
        if (aid !== eid) begin
            n_fail++;
            $display("FAIL %s dut%0d gnt_id got %0d expected %0d", nm, d, aid, eid);
        end
    endtask

    // Apply one cycle of inputs to one DUT, check at the falling edge, advance past the rising edge.
    task automatic step(input int d, input bit rst, input bit cyc, input logic [2:0] req,
                        input string nm, input int w);
        rst_v[d] = rst;
        cyc_v[d] = cyc;
        req_a[d] = req;
        @(negedge clk);
        check(d, nm, w);
        @(posedge clk);
        #1;
    endtask

    function automatic int model_grant(input int d, input model_t s, input bit rst,
                                       input bit cyc, input logic [2:0] req);
        int st;
        if (rst || !cyc) return -1;
        if (s.holding && req[s.owner]) return s.owner;
        st = s.holding ? (s.owner + 1) % nn[d] : s.ptr;
        for (int k = 0; k < nn[d]; k++)
            if (req[(st + k) % nn[d]]) return (st + k) % nn[d];
        return -1;
    endfunction

    function automatic model_t model_next(input int d, input model_t s, input bit rst,
                                          input bit cyc, input int w);
        model_t r = s;
        if (rst) return '{0, 0, 0, 1'b0};
        if (!cyc) return r;
        if (w < 0) begin
            if (r.holding) begin
                r.ptr = (r.owner + 1) % nn[d];
                r.holding = 1'b0;
            end
        end else if (r.holding && w == r.owner) begin
            r.used++;
            if (r.used == bb[d]) begin
                r.holding = 1'b0;
                r.ptr = (r.owner + 1) % nn[d];
            end
        end else begin
            r.owner = w;
            r.used = 1;
            if (bb[d] == 1) r.ptr = (w + 1) % nn[d];
            else r.holding = 1'b1;
        end
        return r;
    endfunction

    initial begin
        vec_t tbl[$];
        for (int d = 0; d < 3; d++) begin
            rst_v[d] = 1'b1;
            cyc_v[d] = 1'b0;
            req_a[d] = 3'b000;
        end
        @(posedge clk);
        #1;

        // dut0: reset hold, early release, backpressure at cnt=2, reset mid-burst
        tbl.push_back('{1'b1, 1'b1, 3'b111, -1});
        tbl.push_back('{1'b1, 1'b1, 3'b111, -1});
        tbl.push_back('{1'b0, 1'b1, 3'b111,  0});
        tbl.push_back('{1'b0, 1'b1, 3'b111,  0});
        tbl.push_back('{1'b0, 1'b1, 3'b110,  1});
        tbl.push_back('{1'b0, 1'b1, 3'b110,  1});
        for (int i = 0; i < 5; i++) tbl.push_back('{1'b0, 1'b0, 3'b111, -1});
        tbl.push_back('{1'b0, 1'b1, 3'b111,  1});
        tbl.push_back('{1'b0, 1'b1, 3'b111,  1});
        tbl.push_back('{1'b0, 1'b1, 3'b111,  2});
        tbl.push_back('{1'b1, 1'b1, 3'b111, -1});
        tbl.push_back('{1'b0, 1'b1, 3'b110,  1});
        tbl.push_back('{1'b0, 1'b1, 3'b000, -1});
        foreach (tbl[i]) step(0, tbl[i].rst, tbl[i].cyc, tbl[i].req, $sformatf("tbl%0d", i), tbl[i].w);

        // dut0: full-request rotation, BURST grants each in order
        step(0, 1'b1, 1'b1, 3'b111, "rot_rst", -1);
        for (int k = 0; k < 24; k++) step(0, 1'b0, 1'b1, 3'b111, "rotation", (k / 4) % 3);

        // dut2: reset ignores req/cycle, then lowest index wins and holds for the burst
        step(2, 1'b1, 1'b1, 3'b011, "c2_rst", -1);
        step(2, 1'b1, 1'b1, 3'b011, "c2_rst", -1);
        for (int k = 0; k < 10; k++) step(2, 1'b0, 1'b1, 3'b011, "c2_burst", (k / 4) % 2);

        // dut1: pure round-robin wrap on a non-power-of-two client count
        step(1, 1'b1, 1'b1, 3'b101, "c3b1_rst", -1);
        for (int k = 0; k < 4; k++) step(1, 1'b0, 1'b1, 3'b101, "c3b1_alt", (k % 2) * 2);
        step(1, 1'b0, 1'b1, 3'b010, "c3b1_to1", 1);
        step(1, 1'b0, 1'b1, 3'b100, "c3b1_wrap2", 2);
        step(1, 1'b0, 1'b1, 3'b111, "c3b1_ptr0", 0);

        // all DUTs: random traffic against the reference model
        for (int d = 0; d < 3; d++) begin
            rst_v[d] = 1'b1;
            cyc_v[d] = 1'b1;
            req_a[d] = 3'b111;
            m[d] = '{0, 0, 0, 1'b0};
        end
        for (int t = 0; t < 800; t++) begin
            for (int d = 0; d < 3; d++) begin
                if (t > 0) begin
                    rst_v[d] = ($urandom_range(0, 49) == 0);
                    cyc_v[d] = ($urandom_range(0, 4) != 0);
                    if ($urandom_range(0, 3) == 0) req_a[d] = 3'($urandom);
                end
                if (d == 2) req_a[d][2] = 1'b0;
            end
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                int w;
                w = model_grant(d, m[d], rst_v[d], cyc_v[d], req_a[d]);
                check(d, "random", w);
                m[d] = model_next(d, m[d], rst_v[d], cyc_v[d], w);
            end
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/router_rr_arbiter.md
Name: router_rr_arbiter

Overview:
Round-robin arbiter with burst hold. It drives the cycle/req/gnt interface of the multi-input router controller. It grants one input FIFO per cycle whenever the output FIFO can accept data. A winning client keeps the grant for up to BURST consecutive grant cycles, which amortises mux/delay-chain switching; the next grant search then starts at the client after it.

Parameters:
CLIENTS, 2, number of requesters (>=2)
BURST, 4, max consecutive grant cycles held by one client (>=1; 1 = pure round-robin)
IDW, $clog2(CLIENTS), width of client index (localparam)
CNTW, $clog2(BURST+1), width of burst counter (localparam)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cycle  in  1  grant enable (output FIFO not full); no grant when low
req  in  CLIENTS  per-client request (input FIFO not empty)
gnt  out  CLIENTS  one-hot grant, combinational from req/cycle/state; wired directly to FIFO pop
gnt_valid  out  1  |gnt
gnt_id  out  IDW  binary index of granted client; 0 when gnt_valid=0

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Registered state: st (IDLE/HOLD), ptr[IDW] (highest-priority client), owner[IDW], cnt[CNTW].
- Reset values: st=IDLE, ptr=0, owner=0, cnt=0. gnt=0, gnt_valid=0 and gnt_id=0 while reset is high, regardless of req/cycle.
- Latency: 0 cycles from req/cycle to gnt. State updates at the clock edge after a grant.
- gnt is always one-hot or zero. It is never asserted for a client whose req is low.
- cycle=0: gnt=0, all state holds (no counting, no pointer motion).
- IDLE, cycle=1:
  - Winner w = first i with req[i]=1, scanning ptr, ptr+1, ... mod CLIENTS. No req: gnt=0, state holds.
  - On a grant: owner<=w, cnt<=1.
  - If BURST==1: ptr<=w+1 mod CLIENTS, stay IDLE. Otherwise st<=HOLD.
- HOLD, cycle=1, req[owner]=1: grant owner; cnt<=cnt+1.
  - If cnt+1==BURST: ptr<=owner+1 mod CLIENTS, st<=IDLE.
- HOLD, cycle=1, req[owner]=0 (owner FIFO drained): release with no bubble. The same cycle does an IDLE-style search starting at owner+1 mod CLIENTS, and state updates as in IDLE.
  - No other req: gnt=0, ptr<=owner+1, st<=IDLE.
- HOLD, cycle=0: hold. The burst resumes when cycle returns. A cycle-low stall does not consume burst.
- Wrap: ptr and search index wrap CLIENTS-1 -> 0. Non-power-of-2 CLIENTS must wrap at CLIENTS, not 2^IDW.
- Fairness: with all clients continuously requesting and cycle=1, each client gets exactly BURST consecutive grants in order 0,1,...,CLIENTS-1,0,...
- Reset mid-burst: next cycle st=IDLE, ptr=0, and the grant goes to the lowest requesting index.

Decomposition:
- Shared package router_pkg: state enum typedef (IDLE, HOLD); function for mod-CLIENTS increment; clog2-derived width constants.
- One sub-module: router_rr_pick. It is a combinational rotate-priority encoder: inputs req, ptr, en; outputs one-hot pick, pick_id, pick_valid.
- The top instantiates one router_rr_pick and selects its start point between ptr and owner+1.

Test Plan:
- Reset/idle: CLIENTS=2, BURST=4. Hold reset with req=2'b11, cycle=1 -> gnt=0. First cycle after reset -> gnt=2'b01, gnt_id=0.
- Burst rotation: CLIENTS=3, BURST=4, req=3'b111, cycle=1 for 24 cycles -> gnt_id sequence 0x4, 1x4, 2x4, repeated twice; never two bits of gnt set.
- Early release: CLIENTS=3, BURST=4, req=111. Drop req[0] after 2 grants to client 0 -> same cycle gnt=3'b010, then 4 grants to client 1.
- Backpressure: during a burst to client 1 (cnt=2), cycle=0 for 5 cycles -> gnt=0, no state change. After cycle=1, client 1 gets exactly 2 more grants, then client 2.
- Wrap/non-pow2: CLIENTS=3, BURST=1, req=3'b101 -> gnt_id alternates 0,2,0,2. With req[2] only after ptr=2 -> grant 2, next ptr=0.
- Reset mid-burst: assert reset while owner=2, cnt=1 -> after release, with req=3'b110, the first grant is client 1.
